// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU front end.
//   XLEN            : machine word / address width (16)
//   opcode_t        : 4-bit opcode carried in instr[15:12]
//   ST_* / fetch_state_t : fetch FSM encodings
//   fetch_entry_t   : instruction buffer entry {instr, pc}
//   instr_opcode()  : extracts the opcode field of an instruction
//   pc_next()       : sequential halfword fetch address (wraps mod 2^16)
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN = 16;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SHL  = 4'h5,
        OP_SHR  = 4'h6,
        OP_LDI  = 4'h7,
        OP_LD   = 4'h8,
        OP_ST   = 4'h9,
        OP_BEQ  = 4'hA,
        OP_BNE  = 4'hB,
        OP_JMP  = 4'hC,
        OP_JAL  = 4'hD,
        OP_SYS  = 4'hE,
        OP_NOP  = 4'hF
    } opcode_t;

    // Raw encodings kept for older code that compares against plain constants.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    typedef enum logic [1:0] {
        FS_IDLE  = ST_IDLE,
        FS_RUN   = ST_RUN,
        FS_FLUSH = ST_FLUSH
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic opcode_t instr_opcode(input logic [XLEN-1:0] instr);
        return opcode_t'(instr[15:12]);
    endfunction

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Two-entry instruction buffer between instruction memory and the decoder.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears contents)
//   push, push_entry : write one entry at the tail
//   pop           : remove the head entry
//   flush         : empty the buffer at the clock edge (wins over push/pop)
//   head          : current head entry (registered storage)
//   full, empty, count : occupancy status
// Push and pop in the same cycle are legal at any occupancy. A push into a
// full buffer without a simultaneous pop is dropped so storage is never
// corrupted; the fetch credit logic upstream keeps that from happening.
// ---------------------------------------------------------------------------
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q,  count_d;
    logic         do_push_s;
    logic         do_pop_s;

    // Next-state computation for storage, pointers and occupancy.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_pop_s  = pop && (count_q != 2'd0);
        do_push_s = push && ((count_q != 2'(DEPTH)) || do_pop_s);
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push_s} - {1'b0, do_pop_s};
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '{instr: 16'h0000, pc: 16'h0000};
            mem_q[1] <= '{instr: 16'h0000, pc: 16'h0000};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == 2'(DEPTH));
    assign empty = (count_q == 2'd0);

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
// Sequential 16-bit instruction fetch unit with a two-entry buffer and
// redirect (branch/jump) flush.
// Parameters:
//   RESET_PC   : first fetch address after reset
//   FIFO_DEPTH : instruction buffer depth (only 2 is supported)
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   imem_req, imem_addr : memory read request / halfword address this cycle
//   imem_rdata          : read data, valid the cycle after imem_req
//   redirect, redirect_pc : taken branch/jump and its target
//   instr_o, pc_o, instr_valid, instr_ready : valid/ready decoder interface
// Optional feature (macro IFETCH_PERF_CNT_EN):
//   fetched_cnt : handshakes with the decoder, wraps
//   flushed_cnt : discarded responses and buffer entries, wraps
// ---------------------------------------------------------------------------
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 16'h0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            instr_valid,
    input  logic            instr_ready
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [15:0]     fetched_cnt,
    output logic [15:0]     flushed_cnt
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    // outstanding_q: a live response arrives this cycle and will be buffered.
    logic            outstanding_q, outstanding_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;

    logic            valid_s;
    logic            hs_s;
    logic [2:0]      credit_s;
    logic            req_s;
    logic            push_s;
    logic            pop_s;

    fetch_entry_t    push_entry_s;
    fetch_entry_t    fifo_head_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [1:0]      fifo_count_s;

    // Handshake, fetch credit and buffer control for the current cycle.
    always_comb begin
        valid_s  = !rst && !fifo_empty_s;
        hs_s     = valid_s && instr_ready;
        // Slots already committed: buffered entries plus the response on
        // its way, minus the entry the decoder takes this cycle.
        credit_s = {1'b0, fifo_count_s} + {2'b00, outstanding_q} - {2'b00, hs_s};
        if (!rst && (state_q == FS_RUN) && (credit_s < 3'd2)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        // A response landing in a redirect cycle belongs to the old stream.
        push_s       = outstanding_q && !redirect && !rst && (!fifo_full_s || hs_s);
        pop_s        = hs_s;
        push_entry_s = '{instr: imem_rdata, pc: out_pc_q};
    end

    // Fetch FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_IDLE:  state_d = FS_RUN;
            FS_RUN: begin
                // Only a request issued in the redirect cycle needs a dead
                // cycle to let its response drain.
                if (redirect && req_s) begin
                    state_d = FS_FLUSH;
                end else begin
                    state_d = FS_RUN;
                end
            end
            FS_FLUSH: state_d = FS_RUN;
            default:  state_d = FS_IDLE;
        endcase
    end

    // Fetch PC and in-flight request tracking.
    always_comb begin
        if (redirect) begin
            fetch_pc_d = {redirect_pc[XLEN-1:1], 1'b0};
        end else if (req_s) begin
            fetch_pc_d = pc_next(fetch_pc_q);
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
        outstanding_d = req_s && !redirect;
        if (req_s) begin
            out_pc_d = fetch_pc_q;
        end else begin
            out_pc_d = out_pc_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FS_IDLE;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= 1'b0;
            out_pc_q      <= 16'h0000;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            out_pc_q      <= out_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .flush      (redirect),
        .head       (fifo_head_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .count      (fifo_count_s)
    );

    assign imem_req    = req_s;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = valid_s;
    assign instr_o     = rst ? 16'h0000 : fifo_head_s.instr;
    assign pc_o        = rst ? 16'h0000 : fifo_head_s.pc;

`ifdef IFETCH_PERF_CNT_EN
    // stale_q: a response from a request issued in a redirect cycle arrives now.
    logic        stale_q, stale_d;
    logic [15:0] fetched_q, fetched_d;
    logic [15:0] flushed_q, flushed_d;
    logic [2:0]  drop_s;

    // Performance counter next values.
    always_comb begin
        stale_d   = req_s && redirect;
        fetched_d = fetched_q + {15'd0, hs_s};
        if (redirect) begin
            // Entries not taken by the decoder, the response landing now and
            // any stale response from an earlier redirect are all lost.
            drop_s = {1'b0, fifo_count_s} - {2'b00, hs_s}
                   + {2'b00, outstanding_q} + {2'b00, stale_q};
        end else begin
            drop_s = {2'b00, stale_q};
        end
        flushed_d = flushed_q + {13'd0, drop_s};
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stale_q   <= 1'b0;
            fetched_q <= 16'h0000;
            flushed_q <= 16'h0000;
        end else begin
            stale_q   <= stale_d;
            fetched_q <= fetched_d;
            flushed_q <= flushed_d;
        end
    end

    assign fetched_cnt = fetched_q;
    assign flushed_cnt = flushed_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch. A memory model answers every request
// with addr+16'h1000 one cycle later; a reference model of the fetch stream
// pushes expected {instr, pc} entries into a scoreboard queue and pops them
// on each decoder handshake. Define IFETCH_PERF_CNT_EN to also check counters.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'hDEAD;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] instr_o;
    logic [15:0] pc_o;
    logic        instr_valid;
    logic        instr_ready;
`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] fetched_cnt;
    logic [15:0] flushed_cnt;
`endif

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_PC    (16'h0000),
        .FIFO_DEPTH  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_o     (instr_o),
        .pc_o        (pc_o),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetched_cnt (fetched_cnt),
        .flushed_cnt (flushed_cnt)
`endif
    );

    // Memory: data for a request appears the following cycle; junk otherwise.
    always @(posedge clk) imem_rdata <= imem_req ? (imem_addr + 16'h1000) : 16'hDEAD;

    int           errors = 0;
    int           checks = 0;
    fetch_entry_t sb_q[$];
    fetch_state_t m_state;
    logic         m_out;
    logic [15:0]  m_out_pc;
    logic [15:0]  m_pc;
    logic         m_stale;
    int           m_fetched;
    int           m_flushed;
    logic         seen_0010;
    logic         seen_wrap;
    logic [15:0]  last_req_addr;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Mid-cycle compare of the DUT against the model, then model update.
    task automatic monitor();
        logic exp_valid;
        logic hs;
        logic exp_req;
        int   occ;
        exp_valid = (sb_q.size() != 0) && !rst;
        check("instr_valid", {15'd0, instr_valid}, {15'd0, exp_valid});
        if (rst) begin
            check("rst_instr_o", instr_o, 16'h0000);
            check("rst_pc_o", pc_o, 16'h0000);
        end else if (exp_valid) begin
            check("instr_o", instr_o, sb_q[0].instr);
            check("pc_o", pc_o, sb_q[0].pc);
        end
        hs      = exp_valid && instr_ready;
        occ     = sb_q.size() + (m_out ? 1 : 0) - (hs ? 1 : 0);
        exp_req = !rst && (m_state == FS_RUN) && (occ < 2);
        check("imem_req", {15'd0, imem_req}, {15'd0, exp_req});
        if (exp_req) check("imem_addr", imem_addr, m_pc);

        if (imem_req === 1'b1) begin
            if (imem_addr[15:4] == 12'h001) seen_0010 = 1'b1;
            if (imem_addr == 16'h0000 && last_req_addr == 16'hFFFE) seen_wrap = 1'b1;
            last_req_addr = imem_addr;
        end
        if (instr_valid === 1'b1 && instr_ready && pc_o[15:4] == 12'h001) seen_0010 = 1'b1;

        if (rst) begin
            sb_q.delete();
            m_state   = FS_IDLE;
            m_pc      = 16'h0000;
            m_out     = 1'b0;
            m_stale   = 1'b0;
            m_fetched = 0;
            m_flushed = 0;
        end else begin
            if (hs) begin
                void'(sb_q.pop_front());
                m_fetched++;
            end
            m_flushed += m_stale ? 1 : 0;
            if (redirect) begin
                m_flushed += sb_q.size() + (m_out ? 1 : 0);
                sb_q.delete();
                m_out   = 1'b0;
                m_stale = exp_req;
                m_pc    = redirect_pc;
                m_state = (m_state == FS_RUN && exp_req) ? FS_FLUSH : FS_RUN;
            end else begin
                if (m_out) sb_q.push_back(fetch_entry_t'{instr: m_out_pc + 16'h1000, pc: m_out_pc});
                m_out = exp_req;
                if (exp_req) begin
                    m_out_pc = m_pc;
                    m_pc     = m_pc + 16'd2;
                end
                m_stale = 1'b0;
                m_state = FS_RUN;
            end
        end
    endtask

    // One clock: compare mid-cycle, then return just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; instr_ready = 1'b1;
        m_state = FS_IDLE; m_pc = 16'h0000; m_out = 1'b0; m_out_pc = 16'h0000;
        m_stale = 1'b0; m_fetched = 0; m_flushed = 0;
        seen_0010 = 1'b0; seen_wrap = 1'b0; last_req_addr = 16'h0000;

        // Reset and streaming with the decoder always ready.
        repeat (3) cycle();
        check("reset_imem_addr", imem_addr, 16'h0000);
        rst = 1'b0;
        cycle();
        check("first_req", {15'd0, imem_req}, 16'd1);
        check("first_addr", imem_addr, 16'h0000);
        cycle();
        cycle();
        check("first_valid", {15'd0, instr_valid}, 16'd1);
        check("first_instr", instr_o, 16'h1000);
        check("first_pc", pc_o, 16'h0000);
        repeat (10) cycle();

        // Decoder stall: buffer fills to two entries and requests stop.
        instr_ready = 1'b0;
        repeat (5) cycle();
        check("stall_req_low", {15'd0, imem_req}, 16'd0);
        check("stall_valid", {15'd0, instr_valid}, 16'd1);
        instr_ready = 1'b1;
        repeat (6) cycle();

        // Redirect with a request in flight.
        check("inflight_req", {15'd0, imem_req}, 16'd1);
        redirect = 1'b1; redirect_pc = 16'h0040;
        cycle();
        redirect = 1'b0;
        check("flush_req_low", {15'd0, imem_req}, 16'd0);
        check("flush_valid_low", {15'd0, instr_valid}, 16'd0);
        cycle();
        check("redirect_req", {15'd0, imem_req}, 16'd1);
        check("redirect_addr", imem_addr, 16'h0040);
        repeat (2) cycle();
        check("redirect_first_pc", pc_o, 16'h0040);
        repeat (4) cycle();

        // Back-to-back redirects: the first target must never be used.
        seen_0010 = 1'b0;
        redirect = 1'b1; redirect_pc = 16'h0010;
        cycle();
        redirect_pc = 16'h0020;
        cycle();
        redirect = 1'b0;
        check("b2b_addr", imem_addr, 16'h0020);
        repeat (8) cycle();
        check("no_0010_stream", {15'd0, seen_0010}, 16'd0);

        // Address wrap from 16'hFFFE to 16'h0000.
        redirect = 1'b1; redirect_pc = 16'hFFFA;
        cycle();
        redirect = 1'b0;
        repeat (8) cycle();
        check("pc_wrap", {15'd0, seen_wrap}, 16'd1);

        // Reset mid-stream, together with a redirect and a ready decoder.
        check("pre_reset_valid", {15'd0, instr_valid}, 16'd1);
        rst = 1'b1; redirect = 1'b1; redirect_pc = 16'h0080;
        cycle();
        rst = 1'b0; redirect = 1'b0;
        check("post_rst_req", {15'd0, imem_req}, 16'd0);
        check("post_rst_valid", {15'd0, instr_valid}, 16'd0);
        check("post_rst_instr", instr_o, 16'h0000);
        check("post_rst_pc", pc_o, 16'h0000);
        check("post_rst_addr", imem_addr, 16'h0000);

        // Ten handshakes, then a flush of a full buffer.
        for (int i = 0; i < 60 && m_fetched < 10; i++) cycle();
        check("ten_fetched", 16'(m_fetched), 16'd10);
        instr_ready = 1'b0;
        repeat (3) cycle();
        redirect = 1'b1; redirect_pc = 16'h0100;
        cycle();
        redirect = 1'b0;
        repeat (3) cycle();
`ifdef IFETCH_PERF_CNT_EN
        check("fetched_cnt", fetched_cnt, 16'd10);
        check("flushed_cnt", flushed_cnt, 16'(m_flushed));
`endif
        instr_ready = 1'b1;
        repeat (4) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
